posit_mult_rr_sched: RTL and testbench
======================================

Name: posit_mult_rr_sched

Overview:
- Shares one combinational posit multiplier (N-bit, es exponent bits) between NREQ requesters.
- Round-robin arbitration over valid/ready request channels; one result channel tagged with the requester index.
- Two-stage stallable pipeline: operand/issue register feeding the multiplier, then a result register. Throughput 1 op/cycle.
- Sits between the PAU front-end request ports and the posit multiplier instance.

Parameters:
- N, 16, posit width.
- es, 3, exponent field width, passed to the multiplier.
- NREQ, 4, number of requesters (>=2).
- TW, 2, tag width, ceil(log2(NREQ)).
- CW, 16, width of completed-op counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*N  operand A; requester i at [i*N +: N].
- req_b  in  NREQ*N  operand B, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_data  out  N  posit product.
- out_tag  out  TW  index of the originating requester.
- out_inf  out  1  multiplier inf flag (either operand NaR).
- out_zero  out  1  multiplier zero flag (both operands zero).
- busy  out  1  either pipeline stage valid.
- done_cnt  out  CW  count of results handed off (out_valid & out_ready); wraps.

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, out_data/out_tag/out_inf/out_zero=0, done_cnt=0, busy=0, rr_ptr=NREQ-1, so requester 0 has top priority first.
- Stage registers:
  - S1 holds a, b, tag, s1_valid.
  - The multiplier is driven from S1, with start tied to s1_valid.
  - S2 holds product, inf, zero, tag, s2_valid. S2 drives out_* directly.
- Enables:
  - s2_en = ~s2_valid | out_ready.
  - s1_en = ~s1_valid | s2_en.
  - On s2_en: S2 <= S1 result and s2_valid <= s1_valid.
  - On s1_en: S1 <= granted operands and s1_valid <= (any req_valid).
- Arbitration (combinational):
  - Search requesters rr_ptr+1, rr_ptr+2, … modulo NREQ. The first with req_valid=1 is granted.
  - req_ready[g] = s1_en for the granted g only. All other req_ready bits are 0.
  - No grant is given when no req_valid is set.
  - rr_ptr <= g only on a handshake (req_valid[g] & req_ready[g]). It holds otherwise, including during stalls.
- Latency: a request accepted at edge t gives out_valid=1 after edge t+1, i.e. 2 cycles, provided out_ready stayed high.
- Stall: out_valid & ~out_ready freezes S2. S1 freezes if valid. req_ready is all-zero while s1_valid & ~s2_en. No data is dropped or duplicated.
- Simultaneous handoff and accept in the same cycle is allowed. The pipeline advances with no bubble.
- out_* stays stable while out_valid & ~out_ready.
- Requesters may deassert req_valid without a handshake. The arbiter does not latch a grant across cycles.
- done_cnt increments by 1 on each out_valid & out_ready, modulo 2^CW. 0xFFFF -> 0x0000.
- busy = s1_valid | s2_valid.
- Result ordering equals acceptance order. Tags are never reordered.
- Flag semantics pass through unchanged:
  - A product with a single zero operand gives out_data=0 and out_zero=0.
  - NaR in either operand gives out_data = 1 followed by N-1 zeros, with out_inf=1.
- Reset asserted mid-operation discards all in-flight ops. Outputs return to reset values within the same cycle.

Test Plan:
- Single op: req0 sends a=0x4000 (1.0), b=0x4400 (2.0), out_ready=1 -> 2 cycles later out_valid=1, out_data=0x4400, out_tag=0, done_cnt=1.
- All four requesters valid continuously with a=b=0x4400 -> grants in order 0,1,2,3,0,…; out_data=0x4800 each cycle; out_tag sequence 0,1,2,3 back-to-back.
- Backpressure: out_ready=0 for 5 cycles with 2 ops in flight -> out_* held stable, req_ready=0; release -> both results emerge in order, no loss or duplication.
- Flags: 0x8000*0x4000 -> out_data=0x8000, out_inf=1; 0x0000*0x0000 -> out_data=0x0000, out_zero=1; 0x0000*0x4000 -> out_data=0x0000, out_zero=0; 0x4000*0xC000 -> out_data=0xC000.
- Fairness after reset: req1 and req3 valid -> req1 granted first, then req3, then req1; the pointer is unchanged while stalled.
- Reset asserted with both stages valid -> out_valid, busy and done_cnt are 0 immediately; after release, req0 wins against req2.

Source files
------------

// File: rtl/posit_mult_rr_sched.sv
// Round-robin front end sharing one combinational posit multiplier between NREQ requesters.
// Two stallable stages: issue register (S1) feeding the multiplier, result register (S2) driving out_*.

module posit_mult #(
    parameter int N  = 16,
    parameter int es = 3
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         start_i,
    output logic [N-1:0] p_o,
    output logic         inf_o,
    output logic         zero_o
);
    localparam int SW = $clog2(N) + es + 3;
    localparam int FW = N - 1 - es;
    localparam int PW = 2 * (FW + 1);
    localparam int WW = 2 + es + PW - 1 + N;
    localparam logic signed [SW-1:0] KMAX = SW'(N - 3);
    localparam logic signed [SW-1:0] KMIN = -SW'(N - 2);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    // Returns {scale, fraction field}; the magnitude is decoded so sign is handled outside.
    function automatic logic [SW+FW-1:0] dec(input logic [N-1:0] x);
        logic [N-2:0] r, rem;
        logic signed [SW-1:0] k;
        int m;
        logic run;
        r   = x[N-1] ? ~x[N-2:0] + 1'b1 : x[N-2:0];
        m   = 0;
        run = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (run && r[i] == r[N-2]) m++;
            else run = 1'b0;
        end
        k   = r[N-2] ? SW'(m - 1) : -SW'(m);
        rem = r << (m + 1);
        return {(k <<< es) + SW'(rem[N-2 -: es]), rem[FW-1:0]};
    endfunction

    logic [SW+FW-1:0] da, db;
    logic signed [SW-1:0] sc, k;
    logic [PW-1:0] prod;
    logic [PW-2:0] frac;
    logic [SW-1:0] sh;
    logic [WW-1:0] word;
    logic signed [WW-1:0] ws;
    logic [N-2:0] top;
    logic [N-1:0] mag, res;
    logic guard, sticky, nar, zany;

    always_comb begin
        da   = dec(a_i);
        db   = dec(b_i);
        prod = PW'({1'b1, da[FW-1:0]}) * PW'({1'b1, db[FW-1:0]});
        sc   = $signed(da[SW+FW-1 -: SW]) + $signed(db[SW+FW-1 -: SW]) + SW'(prod[PW-1]);
        frac = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        k    = sc >>> es;
        sh   = k[SW-1] ? ~k : k;
        // Regime is built by shifting a 10/01 seed: arithmetic fill for runs of ones.
        if (k[SW-1]) begin
            word = {2'b01, sc[es-1:0], frac, {N{1'b0}}};
            word = word >> sh;
        end else begin
            ws   = {2'b10, sc[es-1:0], frac, {N{1'b0}}};
            ws   = ws >>> sh;
            word = ws;
        end
        ws     = '0;
        top    = word[WW-1 -: N-1];
        guard  = word[WW-N];
        sticky = |word[WW-N-1:0];
        mag    = {1'b0, top} + N'(guard & (sticky | top[0]));
        if (k > KMAX)      mag = {1'b0, {(N-1){1'b1}}};
        else if (k < KMIN) mag = N'(1);
        res    = (a_i[N-1] ^ b_i[N-1]) ? -mag : mag;
        nar    = (a_i == NAR) | (b_i == NAR);
        zany   = (a_i == '0) | (b_i == '0);
        p_o    = '0;
        if (start_i) p_o = nar ? NAR : (zany ? '0 : res);
        inf_o  = start_i & nar;
        zero_o = start_i & (a_i == '0) & (b_i == '0);
    end
endmodule

module posit_mult_rr_sched #(
    parameter int N    = 16,
    parameter int es   = 3,
    parameter int NREQ = 4,
    parameter int TW   = 2,
    parameter int CW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [TW-1:0]     out_tag,
    output logic              out_inf,
    output logic              out_zero,
    output logic              busy,
    output logic [CW-1:0]     done_cnt
);
    logic            s1_valid_q, s2_valid_q;
    logic [N-1:0]    s1_a_q, s1_b_q, s2_data_q;
    logic [TW-1:0]   s1_tag_q, s2_tag_q, rr_ptr_q, gnt;
    logic            s2_inf_q, s2_zero_q;
    logic [CW-1:0]   done_cnt_q, done_cnt_d;
    logic            any_vld, s1_en, s2_en;
    logic [N-1:0]    m_p;
    logic            m_inf, m_zero;

    assign s2_en = ~s2_valid_q | out_ready;
    assign s1_en = ~s1_valid_q | s2_en;

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        int idx;
        idx     = 0;
        any_vld = 1'b0;
        gnt     = rr_ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!any_vld && req_valid[idx]) begin
                any_vld = 1'b1;
                gnt     = TW'(idx);
            end
        end
        req_ready = '0;
        if (any_vld && s1_en) req_ready[gnt] = 1'b1;
    end

    posit_mult #(.N(N), .es(es)) u_mult (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .start_i(s1_valid_q),
        .p_o    (m_p),
        .inf_o  (m_inf),
        .zero_o (m_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            rr_ptr_q   <= TW'(NREQ - 1);
        end else if (s1_en) begin
            s1_valid_q <= any_vld;
            s1_a_q     <= req_a[gnt*N +: N];
            s1_b_q     <= req_b[gnt*N +: N];
            s1_tag_q   <= gnt;
            if (any_vld) rr_ptr_q <= gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
            s2_inf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= m_p;
            s2_tag_q   <= s1_tag_q;
            s2_inf_q   <= m_inf;
            s2_zero_q  <= m_zero;
        end
    end

    assign done_cnt_d = done_cnt_q + CW'(s2_valid_q & out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_cnt_q <= '0;
        else     done_cnt_q <= done_cnt_d;
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_inf   = s2_inf_q;
    assign out_zero  = s2_zero_q;
    assign busy      = s1_valid_q | s2_valid_q;
    assign done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_posit_mult_rr_sched.sv
// Directed bench for posit_mult_rr_sched: latency, round-robin order, stalls, flags, reset, counter wrap.

module tb_posit_mult_rr_sched;
    localparam int N = 16, NREQ = 4, TW = 2, CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*N-1:0] req_a, req_b;
    logic              out_valid, out_ready;
    logic [N-1:0]      out_data;
    logic [TW-1:0]     out_tag;
    logic              out_inf, out_zero, busy;
    logic [CW-1:0]     done_cnt;

    int total = 0;
    int bad   = 0;

    posit_mult_rr_sched #(.N(N), .es(3), .NREQ(NREQ), .TW(TW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_inf(out_inf), .out_zero(out_zero),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] a, b, p;
        logic         inf, zero;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h8000, 16'h4000, 16'h8000, 1'b1, 1'b0};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[2] = '{16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{16'h4000, 16'hC000, 16'hC000, 1'b0, 1'b0};
        vecs[4] = '{16'h4200, 16'h4200, 16'h4480, 1'b0, 1'b0};
        vecs[5] = '{16'h4400, 16'hC000, 16'hBC00, 1'b0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
        vecs[7] = '{16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0};

        req_a = '0;
        req_b = '0;
        do_reset();
        rst = 1'b1;
        step();
        chk("rst_ovld", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(done_cnt), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_tag", 32'(out_tag), 0);
        rst = 1'b0;

        // single op, 2-cycle latency
        set_lane(0, 16'h4000, 16'h4400);
        req_valid = 4'b0001;
        #1 chk("t1_rdy", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ovld0", 32'(out_valid), 0);
        step();
        chk("t1_ovld", 32'(out_valid), 1);
        chk("t1_data", 32'(out_data), 32'h4400);
        chk("t1_tag", 32'(out_tag), 0);
        step();
        chk("t1_cnt", 32'(done_cnt), 1);
        chk("t1_idle", 32'(busy), 0);

        // all requesters streaming
        do_reset();
        for (int i = 0; i < NREQ; i++) set_lane(i, 16'h4400, 16'h4400);
        req_valid = 4'b1111;
        for (int s = 0; s < 10; s++) begin
            if (s >= 2) begin
                chk("t2_ovld", 32'(out_valid), 1);
                chk("t2_data", 32'(out_data), 32'h4800);
                chk("t2_tag", 32'(out_tag), 32'((s - 2) % 4));
            end
            #1 chk("t2_rdy", 32'(req_ready), 32'(1 << (s % 4)));
            step();
        end
        req_valid = '0;
        step();
        step();
        chk("t2_cnt", 32'(done_cnt), 10);
        chk("t2_idle", 32'(busy), 0);

        // backpressure with two ops in flight
        do_reset();
        set_lane(0, 16'h4000, 16'h4400);
        set_lane(1, 16'h4400, 16'h4400);
        set_lane(2, 16'h4000, 16'h4000);
        out_ready = 1'b0;
        req_valid = 4'b0001;
        #1 chk("t3_rdy0", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0010;
        #1 chk("t3_rdy1", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0100;
        for (int s = 0; s < 5; s++) begin
            chk("t3_hold_v", 32'(out_valid), 1);
            chk("t3_hold_d", 32'(out_data), 32'h4400);
            chk("t3_hold_t", 32'(out_tag), 0);
            #1 chk("t3_hold_rdy", 32'(req_ready), 0);
            step();
        end
        out_ready = 1'b1;
        req_valid = '0;
        step();
        chk("t3_r1_v", 32'(out_valid), 1);
        chk("t3_r1_d", 32'(out_data), 32'h4800);
        chk("t3_r1_t", 32'(out_tag), 1);
        chk("t3_cnt1", 32'(done_cnt), 1);
        step();
        chk("t3_end_v", 32'(out_valid), 0);
        chk("t3_cnt2", 32'(done_cnt), 2);

        // flag and arithmetic vectors through requester 0
        do_reset();
        for (int s = 0; s < 10; s++) begin
            if (s >= 2) begin
                chk("t4_v", 32'(out_valid), 1);
                chk("t4_d", 32'(out_data), 32'(vecs[s-2].p));
                chk("t4_inf", 32'(out_inf), 32'(vecs[s-2].inf));
                chk("t4_zero", 32'(out_zero), 32'(vecs[s-2].zero));
            end
            if (s < 8) begin
                set_lane(0, vecs[s].a, vecs[s].b);
                req_valid = 4'b0001;
            end else begin
                req_valid = '0;
            end
            step();
        end

        // fairness after reset, pointer held while stalled
        do_reset();
        set_lane(1, 16'h4000, 16'h4000);
        set_lane(3, 16'h4400, 16'h4000);
        req_valid = 4'b1010;
        #1 chk("t5_g1", 32'(req_ready), 32'h2);
        step();
        #1 chk("t5_g3", 32'(req_ready), 32'h8);
        step();
        out_ready = 1'b0;
        #1 chk("t5_stall0", 32'(req_ready), 0);
        chk("t5_tag1", 32'(out_tag), 1);
        step();
        #1 chk("t5_stall1", 32'(req_ready), 0);
        step();
        out_ready = 1'b1;
        #1 chk("t5_g1b", 32'(req_ready), 32'h2);
        step();
        chk("t5_tag3", 32'(out_tag), 3);
        chk("t5_d3", 32'(out_data), 32'h4400);
        req_valid = '0;
        step();
        chk("t5_tag1b", 32'(out_tag), 1);
        step();
        chk("t5_cnt", 32'(done_cnt), 3);

        // reset with both stages occupied
        set_lane(0, 16'h4000, 16'h4000);
        set_lane(2, 16'h4400, 16'h4400);
        out_ready = 1'b0;
        req_valid = 4'b0001;
        step();
        step();
        chk("t6_busy", 32'(busy), 1);
        chk("t6_ovld", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_v", 32'(out_valid), 0);
        chk("t6_rst_b", 32'(busy), 0);
        chk("t6_rst_c", 32'(done_cnt), 0);
        chk("t6_rst_d", 32'(out_data), 0);
        req_valid = 4'b0101;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("t6_g0", 32'(req_ready), 32'h1);
        chk("t6_idle", 32'(out_valid), 0);

        // done counter wraps at 2^CW
        do_reset();
        set_lane(0, 16'h4000, 16'h4000);
        req_valid = 4'b0001;
        for (int s = 0; s < 16; s++) step();
        req_valid = '0;
        step();
        chk("t7_cnt_max", 32'(done_cnt), 15);
        step();
        chk("t7_cnt_wrap", 32'(done_cnt), 0);
        chk("t7_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
